// File: rtl/serdesphy_rx_word_aligner_pkg.sv
// rtl/serdesphy_rx_word_aligner_pkg.sv - shared FSM encodings and defaults for the RX word aligner
package serdesphy_rx_word_aligner_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_t;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;

endpackage

// File: rtl/serdesphy_rx_holding_reg.sv
// rtl/serdesphy_rx_holding_reg.sv - one-entry valid/ready word buffer with sticky overflow flag
module serdesphy_rx_holding_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ready,
  input  logic       status_clear,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow
);

  logic transfer;

  assign transfer = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data     <= 8'h00;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load && (!valid || transfer)) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (transfer) begin
        valid <= 1'b0;
      end
      // A set in the same cycle as a clear must win
      if (load && valid && !transfer) begin
        overflow <= 1'b1;
      end else if (status_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serdesphy_rx_word_aligner.sv
// rtl/serdesphy_rx_word_aligner.sv - hunts for the sync pattern in the CDR bit stream and frames 8-bit words
module serdesphy_rx_word_aligner
  import serdesphy_rx_word_aligner_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int         CONFIRM_COUNT = 2,
  parameter int         MAX_GAP       = 16,
  parameter bit         DROP_SYNC     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  input  logic       rx_word_ready,
  input  logic       rx_status_clear,
  output logic [7:0] rx_data_word,
  output logic       rx_word_valid,
  output logic       rx_locked,
  output logic       rx_overflow
);

  localparam logic [2:0] CONFIRM_TGT = 3'(CONFIRM_COUNT);
  localparam logic [7:0] GAP_TGT     = 8'(MAX_GAP);

  rx_state_t  state, state_next;
  logic [7:0] sr;
  logic [7:0] shifted;
  logic [2:0] bit_cnt;
  logic [2:0] confirm_cnt, confirm_inc;
  logic [7:0] gap_cnt, gap_inc;
  logic       boundary;
  logic       is_sync;
  logic       forward;

  assign shifted     = {rx_bit, sr[7:1]};
  assign is_sync     = (shifted == SYNC_WORD);
  assign boundary    = rx_bit_valid && (bit_cnt == 3'd7);
  assign confirm_inc = (confirm_cnt == 3'd7) ? confirm_cnt : confirm_cnt + 3'd1;
  assign gap_inc     = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_HUNT: begin
        if (rx_bit_valid && is_sync) begin
          state_next = (CONFIRM_COUNT == 1) ? ST_LOCKED : ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (boundary) begin
          if (!is_sync) begin
            state_next = ST_HUNT;
          end else if (confirm_inc >= CONFIRM_TGT) begin
            state_next = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (boundary && !is_sync && (gap_inc >= GAP_TGT)) begin
          state_next = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  always_comb begin
    forward = 1'b0;
    if (state == ST_LOCKED && boundary) begin
      forward = !is_sync || (DROP_SYNC == 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      confirm_cnt <= 3'd0;
      gap_cnt     <= 8'd0;
      rx_locked   <= 1'b0;
    end else begin
      rx_locked <= (state_next == ST_LOCKED);
      if (rx_bit_valid) begin
        sr <= shifted;
      end
      if (state == ST_HUNT) begin
        if (rx_bit_valid && is_sync) begin
          bit_cnt     <= 3'd0;
          confirm_cnt <= 3'd1;
          gap_cnt     <= 8'd0;
        end
      end else if (rx_bit_valid) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (boundary && state == ST_CONFIRM && is_sync) begin
          confirm_cnt <= confirm_inc;
        end
        if (boundary && state == ST_LOCKED) begin
          gap_cnt <= is_sync ? 8'd0 : gap_inc;
        end
      end
      // Falling back to HUNT restarts framing from scratch
      if (state != ST_HUNT && state_next == ST_HUNT) begin
        bit_cnt     <= 3'd0;
        confirm_cnt <= 3'd0;
        gap_cnt     <= 8'd0;
      end
    end
  end

  serdesphy_rx_holding_reg u_holding (
    .clk          (clk),
    .rst          (rst),
    .load         (forward),
    .load_data    (shifted),
    .ready        (rx_word_ready),
    .status_clear (rx_status_clear),
    .data         (rx_data_word),
    .valid        (rx_word_valid),
    .overflow     (rx_overflow)
  );

endmodule

// File: tb/tb_serdesphy_rx_word_aligner.sv
// tb/tb_serdesphy_rx_word_aligner.sv - scoreboard bench for the RX word aligner
module tb_serdesphy_rx_word_aligner;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       rx_word_ready;
  logic       rx_status_clear;
  logic [7:0] rx_data_word;
  logic       rx_word_valid;
  logic       rx_locked;
  logic       rx_overflow;

  int         check_cnt = 0;
  int         pass_cnt  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serdesphy_rx_word_aligner dut (
    .clk             (clk),
    .rst             (rst),
    .rx_bit          (rx_bit),
    .rx_bit_valid    (rx_bit_valid),
    .rx_word_ready   (rx_word_ready),
    .rx_status_clear (rx_status_clear),
    .rx_data_word    (rx_data_word),
    .rx_word_valid   (rx_word_valid),
    .rx_locked       (rx_locked),
    .rx_overflow     (rx_overflow)
  );

  task automatic check(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, actual, expected);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && rx_word_valid && rx_word_ready) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_word: got %02h required none", rx_data_word);
      end else begin
        check("word", int'(rx_data_word), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    rx_bit_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_bit_valid = 1'b0;
    rx_status_clear = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        rx_bit_valid = 1'b0;
        rx_bit = ~b[i];
        @(posedge clk);
        #1;
      end
      rx_bit = b[i];
      rx_bit_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_bit = 1'b0;
    rx_bit_valid = 1'b0;
    rx_word_ready = 1'b1;
    rx_status_clear = 1'b0;
    idle(2);
    do_reset();
    check("reset_valid", rx_word_valid, 0);
    check("reset_data", rx_data_word, 0);
    check("reset_locked", rx_locked, 0);
    check("reset_overflow", rx_overflow, 0);

    // 1: lock on two syncs, two data words
    send_byte(8'hBC, 0);
    check("t1_locked_after_sync1", rx_locked, 0);
    send_byte(8'hBC, 0);
    check("t1_locked_after_sync2", rx_locked, 1);
    check("t1_sync_not_forwarded", rx_word_valid, 0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 0);
    check("t1_latency_a5", rx_word_valid, 1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 0);
    check("t1_latency_3c", rx_word_valid, 1);
    idle(3);

    // 2: junk, sync, non-sync -> no lock
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rx_bit = 1'b1;
      rx_bit_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    send_byte(8'hBC, 0);
    send_byte(8'h12, 0);
    check("t2_locked", rx_locked, 0);
    check("t2_valid", rx_word_valid, 0);
    idle(3);

    // 3: overflow while held, clear, deliver once
    do_reset();
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    rx_word_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 0);
    check("t3_held_valid", rx_word_valid, 1);
    check("t3_no_overflow_yet", rx_overflow, 0);
    send_byte(8'h22, 0);
    check("t3_overflow_set", rx_overflow, 1);
    check("t3_held_data", rx_data_word, 8'h11);
    rx_bit_valid = 1'b0;
    rx_status_clear = 1'b1;
    @(posedge clk);
    #1;
    rx_status_clear = 1'b0;
    check("t3_overflow_cleared", rx_overflow, 0);
    rx_word_ready = 1'b1;
    idle(3);
    check("t3_drained", rx_word_valid, 0);
    check("t3_still_locked", rx_locked, 1);

    // 4: gap limit
    do_reset();
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      send_byte(8'h30 + 8'(i), 0);
      if (i == 14) check("t4_locked_after_15", rx_locked, 1);
    end
    check("t4_locked_after_16", rx_locked, 0);
    check("t4_16th_forwarded", rx_word_valid, 1);
    send_byte(8'h00, 0);
    check("t4_17th_dropped", rx_word_valid, 0);
    idle(3);

    // 5: valid toggling
    do_reset();
    send_byte(8'hBC, 1);
    send_byte(8'hBC, 1);
    check("t5_locked", rx_locked, 1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1);
    check("t5_latency_a5", rx_word_valid, 1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1);
    check("t5_latency_3c", rx_word_valid, 1);
    idle(3);

    // 6: reset mid-word with a held word
    do_reset();
    send_byte(8'hBC, 0);
    send_byte(8'hBC, 0);
    rx_word_ready = 1'b0;
    send_byte(8'h5A, 0);
    check("t6_held", rx_word_valid, 1);
    for (int i = 0; i < 3; i++) begin
      rx_bit = 1'b1;
      rx_bit_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    do_reset();
    check("t6_valid", rx_word_valid, 0);
    check("t6_data", rx_data_word, 0);
    check("t6_locked", rx_locked, 0);
    check("t6_overflow", rx_overflow, 0);
    rx_word_ready = 1'b1;
    send_byte(8'hBC, 0);
    send_byte(8'h33, 0);
    check("t6_hunt_no_word", rx_word_valid, 0);
    check("t6_hunt_no_lock", rx_locked, 0);
    idle(3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
